// File: rtl/mc_pkg.sv
// mc_pkg: shared state encodings, instruction encodings and control codes for the multi-cycle controller.
package mc_pkg;
    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;
    localparam logic [1:0] NPC_RS  = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] DTR_ALU = 2'b00;
    localparam logic [1:0] DTR_MEM = 2'b01;
    localparam logic [1:0] DTR_PC4 = 2'b10;

    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } instr_t;
endpackage

// File: rtl/mc_if.sv
// mc_if: controller-to-datapath/memory signal bundle; master is the controller side.
interface mc_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] npc_sel;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] datato_reg;
    logic       ext_op;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  opcode, funct, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, mem_write, ir_write, pc_write, npc_sel, reg_write,
               reg_dst, alu_src, datato_reg, ext_op, alu_op, instr_done, illegal, bus_err
    );

    modport slave (
        output opcode, funct, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, mem_write, ir_write, pc_write, npc_sel, reg_write,
               reg_dst, alu_src, datato_reg, ext_op, alu_op, instr_done, illegal, bus_err
    );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct to one-hot instruction class; all-zero class means illegal.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output instr_t     cls_o,
    output logic       illegal_o
);
    logic rtype;

    assign rtype       = opcode_i == OP_RTYPE;
    assign cls_o.addu  = rtype && funct_i == FN_ADDU;
    assign cls_o.subu  = rtype && funct_i == FN_SUBU;
    assign cls_o.jr    = rtype && funct_i == FN_JR;
    assign cls_o.ori   = opcode_i == OP_ORI;
    assign cls_o.lui   = opcode_i == OP_LUI;
    assign cls_o.lw    = opcode_i == OP_LW;
    assign cls_o.sw    = opcode_i == OP_SW;
    assign cls_o.beq   = opcode_i == OP_BEQ;
    assign cls_o.j     = opcode_i == OP_J;
    assign cls_o.jal   = opcode_i == OP_JAL;
    assign illegal_o   = ~|cls_o;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with memory ready handshakes and a wait-state timeout.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    mc_if.master bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    instr_t           cls;
    logic             bad;
    logic             to_hit;

    mc_decode u_decode (
        .opcode_i  (bus.opcode),
        .funct_i   (bus.funct),
        .cls_o     (cls),
        .illegal_o (bad)
    );

    assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        bus.imem_req   = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.npc_sel    = NPC_PC4;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = RD_RT;
        bus.alu_src    = 1'b0;
        bus.datato_reg = DTR_ALU;
        bus.ext_op     = 1'b0;
        bus.alu_op     = ALU_ADD;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        bus.bus_err    = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                // a ready on the timeout cycle still completes the fetch
                bus.imem_req = bus.imem_ready || !to_hit;
                if (bus.imem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end else if (to_hit) bus.bus_err = 1'b1;
                else cnt_d = cnt_q + 1'b1;
            end
            S_DECODE: begin
                bus.ext_op = cls.lw | cls.sw | cls.beq;
                if (bad) begin
                    bus.illegal    = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end else if (cls.j) begin
                    bus.pc_write   = 1'b1;
                    bus.npc_sel    = NPC_JMP;
                    bus.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end else state_d = cls.jal ? S_WB : S_EXEC;
            end
            S_EXEC: begin
                bus.ext_op     = cls.lw | cls.sw | cls.beq;
                bus.alu_src    = cls.ori | cls.lui | cls.lw | cls.sw;
                bus.alu_op     = (cls.subu | cls.beq) ? ALU_SUB : cls.ori ? ALU_OR : cls.lui ? ALU_LUI : ALU_ADD;
                bus.pc_write   = cls.jr | (cls.beq & bus.zero);
                bus.npc_sel    = cls.jr ? NPC_RS : cls.beq ? NPC_BR : NPC_PC4;
                bus.instr_done = cls.jr | cls.beq;
                state_d        = (cls.jr | cls.beq) ? S_FETCH : (cls.lw | cls.sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                bus.dmem_req  = bus.dmem_ready || !to_hit;
                bus.mem_write = cls.sw & (bus.dmem_ready | !to_hit);
                if (bus.dmem_ready) begin
                    bus.instr_done = cls.sw;
                    state_d        = cls.sw ? S_FETCH : S_WB;
                end else if (to_hit) begin
                    bus.bus_err = 1'b1;
                    state_d     = S_FETCH;
                end else cnt_d = cnt_q + 1'b1;
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                bus.reg_dst    = (cls.addu | cls.subu) ? RD_RD : cls.jal ? RD_RA : RD_RT;
                bus.datato_reg = cls.lw ? DTR_MEM : cls.jal ? DTR_PC4 : DTR_ALU;
                bus.pc_write   = cls.jal;
                bus.npc_sel    = cls.jal ? NPC_JMP : NPC_PC4;
                state_d        = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the select lines of the RegDst, ALUSrc and DatatoReg muxes, plus all register-file, PC, IR and memory strobes.
- Adds ready handshakes to instruction and data memory, with a wait-state timeout.

Parameters:
- TIMEOUT, 16: max cycles to wait for a memory ready; 0 disables the timeout.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], stable from the cycle after ir_write
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- mem_write  out  1  store strobe, qualifies dmem_req
- ir_write  out  1  IR load enable
- pc_write  out  1  PC load enable
- npc_sel  out  2  next-PC source: 00 PC+4, 01 branch target, 10 jump target, 11 rs
- reg_write  out  1  register-file write enable
- RegDst  out  2  00 rt, 01 rd, 10 $31
- ALUSrc  out  1  0 register, 1 extended immediate
- DatatoReg  out  2  00 ALU, 01 memory, 10 PC+4
- ext_op  out  1  0 zero-extend, 1 sign-extend
- alu_op  out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16)
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported encoding
- bus_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset:
  - Asynchronous assert when reset=0.
  - State goes to S_RST; every output is 0, including all mux selects. Wait counter = 0.
  - First cycle after release: S_RST -> S_FETCH unconditionally.
- State encoding: S_RST=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5. Held in a package.
- Output timing:
  - Outputs decode combinationally from state, opcode and funct.
  - pc_write in EXEC for beq additionally depends on zero.
  - Strobes and mux selects are 0 in every state where they are not listed below.
- S_FETCH:
  - imem_req=1.
  - While imem_ready=0: stay and increment the wait counter.
  - On imem_ready=1: ir_write=1, pc_write=1, npc_sel=00, then go to S_DECODE. Counter clears.
- S_DECODE:
  - ext_op=1 for lw/sw/beq, 0 for ori/lui.
  - Next state by instruction:
    - j: pc_write=1, npc_sel=10, instr_done=1, -> S_FETCH.
    - jal: -> S_WB.
    - Unsupported opcode/funct: illegal=1, instr_done=1, -> S_FETCH, with no other writes.
    - All others: -> S_EXEC.
- Supported encodings:
  - R-type (opcode 000000) with funct addu=100001, subu=100011, jr=001000.
  - ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
- S_EXEC:
  - addu/subu: alu_op=000/001, ALUSrc=0, -> S_WB.
  - ori/lui: alu_op=010/011, ALUSrc=1, -> S_WB.
  - lw/sw: alu_op=000, ALUSrc=1, -> S_MEM.
  - beq: alu_op=001, ALUSrc=0, pc_write=zero, npc_sel=01, instr_done=1, -> S_FETCH.
  - jr: pc_write=1, npc_sel=11, instr_done=1, -> S_FETCH.
- S_MEM:
  - dmem_req=1; mem_write=1 for sw.
  - Stay while dmem_ready=0.
  - On dmem_ready=1: lw -> S_WB; sw asserts instr_done -> S_FETCH.
- S_WB:
  - reg_write=1, instr_done=1, -> S_FETCH.
  - Selects by instruction:
    - R-type: RegDst=01, DatatoReg=00.
    - ori/lui: RegDst=00, DatatoReg=00.
    - lw: RegDst=00, DatatoReg=01.
    - jal: RegDst=10, DatatoReg=10, pc_write=1, npc_sel=10.
  - jal writes PC+4 of the current instruction. PC_address presented to the DatatoReg mux is the instruction's own PC, latched by the datapath at ir_write.
- Timeout:
  - Wait counter counts stall cycles in FETCH/MEM and clears on any state change.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with ready still 0: bus_err=1, drop the request, go to S_FETCH. No PC, IR, register or memory write occurs.
  - A ready arriving on that same cycle wins: normal completion, no bus_err.
- Latencies with zero wait states, FETCH through done:
  - j: 2 cycles.
  - beq, jr, jal: 3 cycles.
  - R-type, ori, lui, sw: 4 cycles.
  - lw: 5 cycles.
- Reset mid-instruction: state is abandoned immediately and outputs go to 0 asynchronously. No partial write is completed.

Decomposition:
- Package mc_pkg: state encodings, opcode/funct constants, alu_op codes, npc_sel/RegDst/DatatoReg codes.
- Sub-module mc_decode: purely combinational opcode/funct -> one-hot instruction class plus illegal flag.
- mc_ctrl holds the FSM, wait counter and output decode.

Test Plan:
- Reset: reset=0 mid-EXEC -> all outputs 0 immediately. Release -> one S_RST cycle, then imem_req=1.
- addu, zero wait: instr_done on cycle 4. In WB: RegDst=01, DatatoReg=00, reg_write=1, and no other strobe set.
- lw with dmem_ready delayed 3 cycles: dmem_req held for 4 cycles. WB follows with DatatoReg=01, RegDst=00. instr_done on cycle 8.
- beq with zero=1 -> pc_write=1, npc_sel=01 in EXEC. Repeat with zero=0 -> pc_write=0; both finish in 3 cycles.
- jal -> DECODE then WB with RegDst=10, DatatoReg=10, reg_write=1, pc_write=1, npc_sel=10. j -> done in 2 cycles with npc_sel=10.
- imem_ready held 0 with TIMEOUT=16 -> bus_err pulse on the 17th FETCH cycle, then FETCH restarts. opcode=111111 -> illegal pulse in DECODE, reg_write never asserted.
